// File: rtl/ledpanel_pkg.sv
// Shared constants, types and pixel-word layout for the LED panel stream path.
package ledpanel_pkg;

   localparam int NUM_PANELS  = 8;
   localparam int WIDTH       = 64;
   localparam int HEIGHT      = 64;
   localparam int INPUT_DEPTH = 24;

   // Column needs exactly log2(WIDTH) bits.
   // Row carries one spare bit so it can step past the last row.
   localparam int BITS_WIDTH  = $clog2(WIDTH);
   localparam int BITS_HEIGHT = $clog2(HEIGHT) + 1;

   localparam int ADDR_BITS = 16;
   localparam int ADDR_PAD  = ADDR_BITS - BITS_HEIGHT - BITS_WIDTH;

   // Bit offsets of the colour channels inside the pixel word.
   // The panel stage decodes the word with the same offsets.
   localparam int R_LSB = 0;
   localparam int G_LSB = 8;
   localparam int B_LSB = 16;

   localparam logic [BITS_WIDTH-1:0]  COL_LAST    = BITS_WIDTH'(WIDTH - 1);
   localparam logic [BITS_HEIGHT-1:0] ROW_LAST    = BITS_HEIGHT'(HEIGHT - 1);
   localparam logic [7:0]             HEIGHT_BYTE = 8'(HEIGHT);
   localparam logic [7:0]             PANEL_MAX   = 8'(NUM_PANELS);

   typedef enum logic [1:0] {
      IDLE,
      HDR_ROW,
      PIX,
      DROP
   } parse_state_t;

   // Index 0 means "no panel".
   // Anything above the panel count addresses hardware that does not exist.
   function automatic logic panel_index_bad(input logic [7:0] idx);
      return (idx == 8'd0) || (idx > PANEL_MAX);
   endfunction

endpackage

// File: rtl/ledpanel_stream_writer_packer.sv
// Collects R, G, B stream bytes into one pixel word.
// A pixel completes combinationally on the B byte.
module rgb_byte_packer
   import ledpanel_pkg::*;
(
   input  logic                   display_clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   byte_valid,
   input  logic [7:0]             byte_in,
   output logic                   pix_valid,
   output logic [INPUT_DEPTH-1:0] pix
);

   logic [1:0] phase;
   logic [7:0] r_hold;
   logic [7:0] g_hold;

   // Byte phase counter and R/G holding registers; clear drops any partial pixel
   always_ff @(posedge display_clock) begin
      if (reset) begin
         phase  <= 2'd0;
         r_hold <= 8'd0;
         g_hold <= 8'd0;
      end else if (clear) begin
         phase <= 2'd0;
      end else if (byte_valid) begin
         case (phase)
            2'd0: begin
               r_hold <= byte_in;
               phase  <= 2'd1;
            end
            2'd1: begin
               g_hold <= byte_in;
               phase  <= 2'd2;
            end
            default: phase <= 2'd0;
         endcase
      end
   end

   // Pixel completes with the blue byte; word assembled from held R/G plus live B
   always_comb begin
      pix_valid         = byte_valid && !clear && (phase == 2'd2);
      pix               = '0;
      pix[R_LSB +: 8]   = r_hold;
      pix[G_LSB +: 8]   = g_hold;
      pix[B_LSB +: 8]   = byte_in;
   end

endmodule

// File: rtl/ledpanel_stream_writer.sv
// Parses panel packets from the byte stream.
// Issues single-cycle pixel writes on the panel control bus.
module ledpanel_stream_writer
   import ledpanel_pkg::*;
(
   input  logic                   display_clock,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   input  logic                   in_sof,
   output logic [7:0]             ctrl_en,
   output logic [ADDR_BITS-1:0]   ctrl_addr,
   output logic [INPUT_DEPTH-1:0] ctrl_wdat,
   output logic                   pkt_done,
   output logic                   pkt_err
);

   parse_state_t state;
   parse_state_t state_d;

   logic [7:0]             panel;
   logic                   hdr_bad;
   logic [BITS_HEIGHT-1:0] row;
   logic [BITS_WIDTH-1:0]  col;

   logic                   sof_seen;
   logic                   data_seen;
   logic                   row_bad;
   logic                   row_load;
   logic                   hdr_fault;
   logic                   sof_abort;
   logic                   last_pixel;
   logic                   byte_valid;
   logic                   packer_clear;
   logic                   pix_valid;
   logic [INPUT_DEPTH-1:0] pix;

   assign sof_seen     = in_valid & in_sof;
   assign data_seen    = in_valid & ~in_sof;
   assign row_bad      = (in_data >= HEIGHT_BYTE);
   assign last_pixel   = (row == ROW_LAST) && (col == COL_LAST);
   assign byte_valid   = data_seen && (state == PIX);
   assign packer_clear = sof_seen | row_load;

   rgb_byte_packer u_packer (
      .display_clock (display_clock),
      .reset         (reset),
      .clear         (packer_clear),
      .byte_valid    (byte_valid),
      .byte_in       (in_data),
      .pix_valid     (pix_valid),
      .pix           (pix)
   );

   // Parser state register
   always_ff @(posedge display_clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next-state logic; a start-of-frame byte restarts header parsing from any state
   always_comb begin
      state_d = state;
      if (sof_seen) begin
         state_d = HDR_ROW;
      end else if (data_seen) begin
         case (state)
            HDR_ROW: state_d = (hdr_bad || row_bad) ? DROP : PIX;
            PIX:     if (pix_valid && last_pixel) state_d = IDLE;
            default: state_d = state;
         endcase
      end
   end

   // Per-cycle control decode
   // Header faults are flagged on the row byte.
   // A SOF landing in PIX always means an unfinished panel.
   always_comb begin
      row_load  = 1'b0;
      hdr_fault = 1'b0;
      sof_abort = 1'b0;
      case (state)
         HDR_ROW: begin
            if (data_seen) begin
               if (hdr_bad || row_bad) hdr_fault = 1'b1;
               else                    row_load  = 1'b1;
            end
         end
         PIX:     sof_abort = sof_seen;
         default: ;
      endcase
   end

   // Header register: the panel byte is kept and judged as soon as it arrives
   always_ff @(posedge display_clock) begin
      if (reset) begin
         panel   <= 8'd0;
         hdr_bad <= 1'b0;
      end else if (sof_seen) begin
         panel   <= in_data;
         hdr_bad <= panel_index_bad(in_data);
      end
   end

   // Raster address counters: column wraps at the row end and carries into the row
   always_ff @(posedge display_clock) begin
      if (reset) begin
         row <= '0;
         col <= '0;
      end else if (row_load) begin
         row <= in_data[BITS_HEIGHT-1:0];
         col <= '0;
      end else if (pix_valid) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Registered control-bus outputs; address and data hold between writes
   always_ff @(posedge display_clock) begin
      if (reset) begin
         ctrl_en   <= 8'd0;
         ctrl_addr <= '0;
         ctrl_wdat <= '0;
         pkt_done  <= 1'b0;
         pkt_err   <= 1'b0;
      end else begin
         ctrl_en  <= pix_valid ? panel : 8'd0;
         pkt_done <= pix_valid & last_pixel;
         pkt_err  <= hdr_fault | sof_abort;
         if (pix_valid) begin
            ctrl_addr <= {{ADDR_PAD{1'b0}}, row, col};
            ctrl_wdat <= pix;
         end
      end
   end

endmodule
